// File: rtl/mem2_load_stage_pkg.sv
// Shared definitions for the MEM2 load stage: load-type encoding,
// writeback select values and the response-tracking state machine states.
package mem2_load_stage_pkg;

    typedef struct packed {
        logic       read_mem;
        logic [2:0] kind;
    } load_type_t;

    localparam logic [2:0] KIND_LB  = 3'd0;
    localparam logic [2:0] KIND_LBU = 3'd1;
    localparam logic [2:0] KIND_LH  = 3'd2;
    localparam logic [2:0] KIND_LHU = 3'd3;
    localparam logic [2:0] KIND_LW  = 3'd4;
    localparam logic [2:0] KIND_LWL = 3'd5;
    localparam logic [2:0] KIND_LWR = 3'd6;

    localparam logic [1:0] WB_PC8  = 2'd0;
    localparam logic [1:0] WB_ALU  = 2'd1;
    localparam logic [1:0] WB_OUTB = 2'd2;
    localparam logic [1:0] WB_LOAD = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD,
        S_DRAIN
    } mem2_state_t;

endpackage

// File: rtl/mem2_load_stage_load_align.sv
// Pure combinational load aligner: selects and extends the addressed
// byte/halfword or merges an unaligned LWL/LWR word with the old rt value.
module load_align
    import mem2_load_stage_pkg::*;
(
    input  logic [2:0]  kind,
    input  logic [1:0]  k,
    input  logic [31:0] d,
    input  logic [31:0] rt,
    output logic [31:0] value
);

    logic [4:0]  lwr_shift;
    logic [4:0]  lwl_shift;
    logic [5:0]  lwl_mask_shift;
    logic [31:0] shifted_down;
    logic [31:0] lwl_mask;
    logic [31:0] lwr_mask;
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    // A mask shift of 32 (LWL with k=3) yields an all-zero mask: rt is fully replaced.
    always_comb begin
        lwr_shift      = {k, 3'b000};
        lwl_shift      = {2'd3 - k, 3'b000};
        lwl_mask_shift = {{1'b0, k} + 3'd1, 3'b000};
        shifted_down   = d >> lwr_shift;
        lwl_mask       = 32'hFFFF_FFFF >> lwl_mask_shift;
        lwr_mask       = ~(32'hFFFF_FFFF >> lwr_shift);
        byte_val       = shifted_down[7:0];
        half_val       = k[1] ? d[31:16] : d[15:0];
        value          = d;
        case (kind)
            KIND_LB:  value = {{24{byte_val[7]}}, byte_val};
            KIND_LBU: value = {24'd0, byte_val};
            KIND_LH:  value = {{16{half_val[15]}}, half_val};
            KIND_LHU: value = {16'd0, half_val};
            KIND_LW:  value = d;
            KIND_LWL: value = (d << lwl_shift) | (rt & lwl_mask);
            KIND_LWR: value = shifted_down | (rt & lwr_mask);
            default:  value = d;
        endcase
    end

endmodule

// File: rtl/mem2_load_stage.sv
// MEM2 pipeline stage: latches the MEM instruction, tracks the outstanding
// DCache read response, and produces the aligned writeback value and stall.
module mem2_load_stage
    import mem2_load_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM2_Wr,
    input  logic        MEM2_Flush,
    input  logic [31:0] MEM_PC,
    input  logic [31:0] MEM_Instr,
    input  logic [31:0] MEM_ALUOut,
    input  logic [31:0] MEM_OutB,
    input  logic [4:0]  MEM_Dst,
    input  logic        MEM_RegWr,
    input  logic [1:0]  MEM_WbSel,
    input  logic [3:0]  MEM_LoadType,
    input  logic        MEM_ExcValid,
    input  logic        dcache_rvalid,
    input  logic [31:0] dcache_rdata,
    output logic [31:0] MEM2_PC,
    output logic [31:0] MEM2_Instr,
    output logic [4:0]  MEM2_Dst,
    output logic        MEM2_RegWr,
    output logic [31:0] MEM2_Result,
    output logic        MEM2_LoadStall
);

    load_type_t  mem_load;
    mem2_state_t state, next_state;
    logic [31:0] alu_out, out_b, hold_q, load_src, aligned;
    logic [1:0]  wb_sel;
    logic [2:0]  load_kind;
    logic        ld_pend, new_pend, next_pend;

    assign mem_load = load_type_t'(MEM_LoadType);
    assign new_pend = mem_load.read_mem & ~MEM_ExcValid;

    always_ff @(posedge clk) begin
        if (rst || MEM2_Flush) begin
            MEM2_PC    <= RESET_PC;
            MEM2_Instr <= '0;
            MEM2_Dst   <= '0;
            MEM2_RegWr <= 1'b0;
            alu_out    <= '0;
            out_b      <= '0;
            wb_sel     <= '0;
            load_kind  <= '0;
            ld_pend    <= 1'b0;
        end else if (MEM2_Wr) begin
            MEM2_PC    <= MEM_PC;
            MEM2_Instr <= MEM_Instr;
            MEM2_Dst   <= MEM_Dst;
            MEM2_RegWr <= MEM_RegWr & ~MEM_ExcValid;
            alu_out    <= MEM_ALUOut;
            out_b      <= MEM_OutB;
            wb_sel     <= MEM_WbSel;
            load_kind  <= mem_load.kind;
            ld_pend    <= new_pend;
        end
    end

    // A response that arrives while the pipeline is frozen is parked in hold_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            hold_q <= '0;
        end else begin
            state <= next_state;
            if (state == S_WAIT && dcache_rvalid && !MEM2_Wr && !MEM2_Flush)
                hold_q <= dcache_rdata;
        end
    end

    always_comb begin
        next_state = state;
        next_pend  = MEM2_Flush ? 1'b0 : (MEM2_Wr ? new_pend : ld_pend);
        case (state)
            S_IDLE: begin
                if (MEM2_Wr && !MEM2_Flush && new_pend)
                    next_state = S_WAIT;
            end
            S_WAIT: begin
                if (dcache_rvalid) begin
                    if (MEM2_Flush)
                        next_state = S_IDLE;
                    else if (MEM2_Wr)
                        next_state = next_pend ? S_WAIT : S_IDLE;
                    else
                        next_state = S_HOLD;
                end else if (MEM2_Flush) begin
                    next_state = S_DRAIN;
                end
            end
            S_HOLD: begin
                if (MEM2_Flush)
                    next_state = S_IDLE;
                else if (MEM2_Wr)
                    next_state = next_pend ? S_WAIT : S_IDLE;
            end
            S_DRAIN: begin
                // The stale response is dropped; a load captured meanwhile now waits for its own.
                if (dcache_rvalid)
                    next_state = next_pend ? S_WAIT : S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        load_src = '0;
        if (state == S_WAIT && dcache_rvalid)
            load_src = dcache_rdata;
        else if (state == S_HOLD)
            load_src = hold_q;
    end

    load_align u_align (
        .kind  (load_kind),
        .k     (alu_out[1:0]),
        .d     (load_src),
        .rt    (out_b),
        .value (aligned)
    );

    always_comb begin
        MEM2_Result = aligned;
        case (wb_sel)
            WB_PC8:  MEM2_Result = MEM2_PC + 32'd8;
            WB_ALU:  MEM2_Result = alu_out;
            WB_OUTB: MEM2_Result = out_b;
            default: MEM2_Result = aligned;
        endcase
    end

    assign MEM2_LoadStall = ld_pend && (state == S_WAIT || state == S_DRAIN)
                            && !(state == S_WAIT && dcache_rvalid);

endmodule

// File: tb/tb_mem2_load_stage.sv
// Directed self-checking bench for mem2_load_stage: reset values, cache hits
// for every load kind, miss with HOLD, flush with stale response, exceptions.
module tb_mem2_load_stage;
    import mem2_load_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        MEM2_Wr, MEM2_Flush;
    logic [31:0] MEM_PC, MEM_Instr, MEM_ALUOut, MEM_OutB;
    logic [4:0]  MEM_Dst;
    logic        MEM_RegWr;
    logic [1:0]  MEM_WbSel;
    logic [3:0]  MEM_LoadType;
    logic        MEM_ExcValid;
    logic        dcache_rvalid;
    logic [31:0] dcache_rdata;
    logic [31:0] MEM2_PC, MEM2_Instr, MEM2_Result;
    logic [4:0]  MEM2_Dst;
    logic        MEM2_RegWr, MEM2_LoadStall;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem2_load_stage #(.RESET_PC(32'hBFC0_0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .MEM2_Wr       (MEM2_Wr),
        .MEM2_Flush    (MEM2_Flush),
        .MEM_PC        (MEM_PC),
        .MEM_Instr     (MEM_Instr),
        .MEM_ALUOut    (MEM_ALUOut),
        .MEM_OutB      (MEM_OutB),
        .MEM_Dst       (MEM_Dst),
        .MEM_RegWr     (MEM_RegWr),
        .MEM_WbSel     (MEM_WbSel),
        .MEM_LoadType  (MEM_LoadType),
        .MEM_ExcValid  (MEM_ExcValid),
        .dcache_rvalid (dcache_rvalid),
        .dcache_rdata  (dcache_rdata),
        .MEM2_PC       (MEM2_PC),
        .MEM2_Instr    (MEM2_Instr),
        .MEM2_Dst      (MEM2_Dst),
        .MEM2_RegWr    (MEM2_RegWr),
        .MEM2_Result   (MEM2_Result),
        .MEM2_LoadStall(MEM2_LoadStall)
    );

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mem(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] outb,
                           input logic [4:0] dst, input logic regwr, input logic [1:0] wbsel,
                           input logic [3:0] ldtype, input logic exc);
        MEM_PC       = pc;
        MEM_Instr    = pc ^ 32'h8C00_0000;
        MEM_ALUOut   = alu;
        MEM_OutB     = outb;
        MEM_Dst      = dst;
        MEM_RegWr    = regwr;
        MEM_WbSel    = wbsel;
        MEM_LoadType = ldtype;
        MEM_ExcValid = exc;
    endtask

    task automatic set_nop();
        set_mem(32'h0040_0200, 32'h5555_AAAA, 32'h0, 5'd0, 1'b0, WB_ALU, 4'h0, 1'b0);
    endtask

    task automatic apply_stimulus_hit(input string tag, input logic [2:0] kind, input logic [31:0] addr,
                                      input logic [31:0] rt, input logic [31:0] rdata,
                                      input logic [31:0] expected);
        set_mem(32'h0040_0100, addr, rt, 5'd7, 1'b1, WB_LOAD, {1'b1, kind}, 1'b0);
        MEM2_Wr = 1'b1;
        dcache_rvalid = 1'b0;
        next_cycle();
        set_nop();
        dcache_rvalid = 1'b1;
        dcache_rdata  = rdata;
        @(negedge clk);
        check_output(tag, MEM2_Result, expected);
        check_output({tag, "_stall"}, {31'd0, MEM2_LoadStall}, 32'd0);
        next_cycle();
        dcache_rvalid = 1'b0;
        MEM2_Wr = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        MEM2_Wr = 1'b0;
        MEM2_Flush = 1'b0;
        dcache_rvalid = 1'b0;
        dcache_rdata = '0;
        set_nop();
        repeat (2) next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check_output("rst_pc", MEM2_PC, 32'hBFC0_0000);
        check_output("rst_instr", MEM2_Instr, 32'h0);
        check_output("rst_dst", {27'd0, MEM2_Dst}, 32'h0);
        check_output("rst_regwr", {31'd0, MEM2_RegWr}, 32'h0);
        check_output("rst_result", MEM2_Result, 32'hBFC0_0008);
        check_output("rst_stall", {31'd0, MEM2_LoadStall}, 32'h0);
        next_cycle();

        // LW hit, also checking the registered fields of the resident load
        set_mem(32'h0040_0100, 32'h1000_0004, 32'h0, 5'd9, 1'b1, WB_LOAD, {1'b1, KIND_LW}, 1'b0);
        MEM2_Wr = 1'b1;
        next_cycle();
        set_nop();
        dcache_rvalid = 1'b1;
        dcache_rdata = 32'h8899_AABB;
        @(negedge clk);
        check_output("lw_hit", MEM2_Result, 32'h8899_AABB);
        check_output("lw_hit_stall", {31'd0, MEM2_LoadStall}, 32'h0);
        check_output("lw_hit_regwr", {31'd0, MEM2_RegWr}, 32'h1);
        check_output("lw_hit_dst", {27'd0, MEM2_Dst}, 32'd9);
        check_output("lw_hit_pc", MEM2_PC, 32'h0040_0100);
        next_cycle();
        dcache_rvalid = 1'b0;
        MEM2_Wr = 1'b0;
        @(negedge clk);
        check_output("nop_alu", MEM2_Result, 32'h5555_AAAA);
        check_output("nop_regwr", {31'd0, MEM2_RegWr}, 32'h0);
        next_cycle();

        apply_stimulus_hit("lb_k3",  KIND_LB,  32'h1000_0003, 32'h0, 32'h8011_2233, 32'hFFFF_FF80);
        apply_stimulus_hit("lbu_k3", KIND_LBU, 32'h1000_0003, 32'h0, 32'h8011_2233, 32'h0000_0080);
        apply_stimulus_hit("lb_k1",  KIND_LB,  32'h1000_0001, 32'h0, 32'h8011_2233, 32'h0000_0022);
        apply_stimulus_hit("lhu_k2", KIND_LHU, 32'h1000_0002, 32'h0, 32'hBEEF_0000, 32'h0000_BEEF);
        apply_stimulus_hit("lh_k2",  KIND_LH,  32'h1000_0002, 32'h0, 32'hBEEF_0000, 32'hFFFF_BEEF);
        apply_stimulus_hit("lh_k0",  KIND_LH,  32'h1000_0000, 32'h0, 32'h1234_8001, 32'hFFFF_8001);
        apply_stimulus_hit("lwl_k1", KIND_LWL, 32'h1000_0001, 32'h1122_3344, 32'hAABB_CCDD, 32'hCCDD_3344);
        apply_stimulus_hit("lwr_k2", KIND_LWR, 32'h1000_0002, 32'h1122_3344, 32'hAABB_CCDD, 32'h1122_AABB);
        apply_stimulus_hit("lwl_k3", KIND_LWL, 32'h1000_0003, 32'h1122_3344, 32'hAABB_CCDD, 32'hAABB_CCDD);
        apply_stimulus_hit("lwr_k0", KIND_LWR, 32'h1000_0000, 32'h1122_3344, 32'hAABB_CCDD, 32'hAABB_CCDD);

        // PC+8 wraps, OutB select
        set_mem(32'hFFFF_FFFC, 32'h0, 32'h0, 5'd31, 1'b1, WB_PC8, 4'h0, 1'b0);
        MEM2_Wr = 1'b1;
        next_cycle();
        set_mem(32'h0040_0300, 32'h0, 32'h1357_9BDF, 5'd3, 1'b1, WB_OUTB, 4'h0, 1'b0);
        @(negedge clk);
        check_output("pc8_wrap", MEM2_Result, 32'h0000_0004);
        next_cycle();
        MEM2_Wr = 1'b0;
        @(negedge clk);
        check_output("outb_sel", MEM2_Result, 32'h1357_9BDF);
        next_cycle();

        // Miss with 5-cycle latency, response parked in HOLD while frozen
        set_mem(32'h0040_0400, 32'h1000_0008, 32'h0, 5'd4, 1'b1, WB_LOAD, {1'b1, KIND_LW}, 1'b0);
        MEM2_Wr = 1'b1;
        next_cycle();
        MEM2_Wr = 1'b0;
        set_nop();
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check_output($sformatf("miss_stall_%0d", i), {31'd0, MEM2_LoadStall}, 32'h1);
            next_cycle();
        end
        dcache_rvalid = 1'b1;
        dcache_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        check_output("miss_rvalid_stall", {31'd0, MEM2_LoadStall}, 32'h0);
        check_output("miss_rvalid_data", MEM2_Result, 32'hCAFE_F00D);
        next_cycle();
        dcache_rvalid = 1'b0;
        dcache_rdata = 32'h0BAD_0BAD;
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk);
            check_output($sformatf("hold_data_%0d", i), MEM2_Result, 32'hCAFE_F00D);
            check_output($sformatf("hold_stall_%0d", i), {31'd0, MEM2_LoadStall}, 32'h0);
            next_cycle();
        end
        MEM2_Wr = 1'b1;
        @(negedge clk);
        check_output("hold_release", MEM2_Result, 32'hCAFE_F00D);
        next_cycle();
        MEM2_Wr = 1'b0;
        @(negedge clk);
        check_output("after_hold_alu", MEM2_Result, 32'h5555_AAAA);
        next_cycle();

        // Flush in WAIT, stale response discarded, real response used
        set_mem(32'h0040_0500, 32'h1000_000C, 32'h0, 5'd5, 1'b1, WB_LOAD, {1'b1, KIND_LW}, 1'b0);
        MEM2_Wr = 1'b1;
        next_cycle();
        MEM2_Wr = 1'b0;
        MEM2_Flush = 1'b1;
        @(negedge clk);
        check_output("flush_wait_stall", {31'd0, MEM2_LoadStall}, 32'h1);
        next_cycle();
        MEM2_Flush = 1'b0;
        set_mem(32'h0040_0600, 32'h1000_0010, 32'h0, 5'd6, 1'b1, WB_LOAD, {1'b1, KIND_LW}, 1'b0);
        MEM2_Wr = 1'b1;
        @(negedge clk);
        check_output("flush_pc", MEM2_PC, 32'hBFC0_0000);
        check_output("flush_regwr", {31'd0, MEM2_RegWr}, 32'h0);
        check_output("drain_c1_stall", {31'd0, MEM2_LoadStall}, 32'h0);
        next_cycle();
        MEM2_Wr = 1'b0;
        set_nop();
        dcache_rvalid = 1'b1;
        dcache_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check_output("drain_c2_stall", {31'd0, MEM2_LoadStall}, 32'h1);
        next_cycle();
        dcache_rvalid = 1'b0;
        @(negedge clk);
        check_output("drain_c3_stall", {31'd0, MEM2_LoadStall}, 32'h1);
        next_cycle();
        dcache_rvalid = 1'b1;
        dcache_rdata = 32'h1234_5678;
        MEM2_Wr = 1'b1;
        @(negedge clk);
        check_output("drain_c4_stall", {31'd0, MEM2_LoadStall}, 32'h0);
        check_output("drain_c4_data", MEM2_Result, 32'h1234_5678);
        next_cycle();
        dcache_rvalid = 1'b0;
        MEM2_Wr = 1'b0;

        // Load that took an exception in MEM: no pending response, no write
        set_mem(32'h0040_0700, 32'h1000_0014, 32'h0, 5'd8, 1'b1, WB_LOAD, {1'b1, KIND_LW}, 1'b1);
        MEM2_Wr = 1'b1;
        next_cycle();
        MEM2_Wr = 1'b0;
        set_nop();
        @(negedge clk);
        check_output("exc_stall", {31'd0, MEM2_LoadStall}, 32'h0);
        check_output("exc_regwr", {31'd0, MEM2_RegWr}, 32'h0);
        check_output("exc_result", MEM2_Result, 32'h0);
        next_cycle();

        // Reset while waiting on a miss
        set_mem(32'h0040_0800, 32'h1000_0018, 32'h0, 5'd10, 1'b1, WB_LOAD, {1'b1, KIND_LW}, 1'b0);
        MEM2_Wr = 1'b1;
        next_cycle();
        MEM2_Wr = 1'b0;
        @(negedge clk);
        check_output("pre_rst_stall", {31'd0, MEM2_LoadStall}, 32'h1);
        next_cycle();
        rst = 1'b1;
        next_cycle();
        @(negedge clk);
        check_output("wait_rst_pc", MEM2_PC, 32'hBFC0_0000);
        check_output("wait_rst_instr", MEM2_Instr, 32'h0);
        check_output("wait_rst_dst", {27'd0, MEM2_Dst}, 32'h0);
        check_output("wait_rst_regwr", {31'd0, MEM2_RegWr}, 32'h0);
        check_output("wait_rst_result", MEM2_Result, 32'hBFC0_0008);
        check_output("wait_rst_stall", {31'd0, MEM2_LoadStall}, 32'h0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check_output("post_rst_stall", {31'd0, MEM2_LoadStall}, 32'h0);
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
